cdb_arbiter: RTL



---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_arbiter_rr_pick.sv | 42 ++++
 rtl/cdb_arbiter.sv | 70 +++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter types: default requester count, unit index names and
// the modulo-wrap pointer helper.
package cdb_arbiter_pkg;

  localparam int CDB_ARB_NUM_REQ = 2;

  typedef enum logic [0:0] {
    CDB_REQ_IEU = 1'b0,
    CDB_REQ_LSU = 1'b1
  } cdb_req_e;

  // Successor of a winner index; wraps at n so non-power-of-2 pointers stay legal.
  function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotate-priority-rotate picker: first set req bit at or after
// ptr (modulo NUM_REQ) wins; returns one-hot grant and binary winner index.
module cdb_arb_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_ARB_NUM_REQ,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      win,
  output logic               any
);

  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PW-1:0]        ofs;
  logic [PW:0]          sum;

  // Doubling the vector makes the right shift a rotation for any NUM_REQ.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    ofs = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ofs = PW'(i);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, ofs};
    if (sum >= NR) sum = sum - NR;
    win = sum[PW-1:0];
    gnt = any ? (NUM_REQ'(1) << win) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: holds the priority pointer, gates grants in reset,
// and (with CDB_ARB_PERF_EN defined) keeps saturating grant/conflict counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = CDB_ARB_NUM_REQ,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_cdb_busy,
  input  logic                          i_perf_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  o_perf_gnt_cnt,
  output logic [CNT_WIDTH-1:0]          o_perf_conflict_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win;
  logic [NUM_REQ-1:0] pick;
  logic               any;

  cdb_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick),
    .win (win),
    .any (any)
  );

  assign o_gnt      = rst ? '0 : pick;
  assign o_cdb_busy = |o_gnt;

  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (any) ptr <= PW'(rr_next(32'(win), NUM_REQ));
  end

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] gcnt;
  logic [CNT_WIDTH-1:0]              ccnt;
  logic                              conflict;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign conflict = |(i_req & (i_req - NUM_REQ'(1)));

  always_ff @(posedge clk) begin
    if (rst || i_perf_clr) begin
      gcnt <= '0;
      ccnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (o_gnt[k] && gcnt[k] != '1) gcnt[k] <= gcnt[k] + CNT_WIDTH'(1);
      if (conflict && ccnt != '1) ccnt <= ccnt + CNT_WIDTH'(1);
    end
  end

  assign o_perf_gnt_cnt      = gcnt;
  assign o_perf_conflict_cnt = ccnt;
`else
  logic unused_perf_clr;
  assign unused_perf_clr     = i_perf_clr;
  assign o_perf_gnt_cnt      = '0;
  assign o_perf_conflict_cnt = '0;
`endif

endmodule
